// File: rtl/spi_burst_sequencer.sv
// SPI burst sequencer: decodes framed SPI byte streams into config-memory
// writes, readback address sequencing and sticky ready/error flags.
//
// Ports:
//   SCLK               in   SPI clock, all state updates on its rising edge
//   RESET              in   asynchronous, active-high reset
//   SS                 in   chip select, active-low; high aborts the frame
//   data_valid         in   one-cycle strobe, byte present on received_data
//   received_data[7:0] in   byte from the SPI byte slave
//   mem_addr[ADDR_W-1:0] out memory address (write and readback)
//   mem_wdata[7:0]     out  memory write data
//   mem_we             out  one-cycle write strobe per data byte
//   clk_div_ready      out  sticky, set by SET_CLK_DIV
//   input_spike_ready  out  sticky, set by SET_SPIKE
//   debug_config_ready out  sticky, set by SET_DEBUG
//   addr_error         out  sticky, start address beyond MEM_DEPTH-1
//   checksum[7:0]      out  XOR of data bytes written in the current frame
//
// Build option: define SPI_BURST_CHECKSUM_EN to include the checksum
// register; otherwise checksum is tied to 8'h00.

module spi_burst_sequencer #(
    parameter int MEM_DEPTH = 272,
    parameter int ADDR_W    = 9
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              SS,
    input  logic              data_valid,
    input  logic [7:0]        received_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              clk_div_ready,
    output logic              input_spike_ready,
    output logic              debug_config_ready,
    output logic              addr_error,
    output logic [7:0]        checksum
);

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_CLK_DIV = 8'h03;
    localparam logic [7:0] OP_SPIKE   = 8'h04;
    localparam logic [7:0] OP_DEBUG   = 8'h05;
    localparam logic [7:0] OP_CLEAR   = 8'h06;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic              addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              mem_we_d;
    logic              clk_div_d;
    logic              spike_d;
    logic              debug_d;
    logic              addr_err_d;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_addr;

`ifdef SPI_BURST_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

    // Address bit 8 comes from bit 0 of the ADDR_H byte.
    assign start_addr = ADDR_W'({addr_hi_q, received_data});

    // Bursts wrap at the top of the memory, not at the address width.
    assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q            <= S_IDLE;
            is_write_q         <= 1'b0;
            addr_hi_q          <= 1'b0;
            addr_q             <= '0;
            mem_addr           <= '0;
            mem_wdata          <= 8'h00;
            mem_we             <= 1'b0;
            clk_div_ready      <= 1'b0;
            input_spike_ready  <= 1'b0;
            debug_config_ready <= 1'b0;
            addr_error         <= 1'b0;
`ifdef SPI_BURST_CHECKSUM_EN
            csum_q             <= 8'h00;
`endif
        end else begin
            state_q            <= state_d;
            is_write_q         <= is_write_d;
            addr_hi_q          <= addr_hi_d;
            addr_q             <= addr_d;
            mem_addr           <= mem_addr_d;
            mem_wdata          <= mem_wdata_d;
            mem_we             <= mem_we_d;
            clk_div_ready      <= clk_div_d;
            input_spike_ready  <= spike_d;
            debug_config_ready <= debug_d;
            addr_error         <= addr_err_d;
`ifdef SPI_BURST_CHECKSUM_EN
            csum_q             <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        clk_div_d   = clk_div_ready;
        spike_d     = input_spike_ready;
        debug_d     = debug_config_ready;
        addr_err_d  = addr_error;
`ifdef SPI_BURST_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        // Chip select high wins over a coincident byte strobe, so a byte
        // arriving with the deselect edge is never written.
        if (SS) begin
            state_d = S_IDLE;
        end else if (data_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    case (received_data)
                        OP_WRITE, OP_READ: begin
                            state_d    = S_ADDR_H;
                            is_write_d = (received_data == OP_WRITE);
`ifdef SPI_BURST_CHECKSUM_EN
                            csum_d     = 8'h00;
`endif
                        end
                        OP_CLK_DIV: begin
                            state_d   = S_DISCARD;
                            clk_div_d = 1'b1;
                        end
                        OP_SPIKE: begin
                            state_d = S_DISCARD;
                            spike_d = 1'b1;
                        end
                        OP_DEBUG: begin
                            state_d = S_DISCARD;
                            debug_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d    = S_DISCARD;
                            clk_div_d  = 1'b0;
                            spike_d    = 1'b0;
                            debug_d    = 1'b0;
                            addr_err_d = 1'b0;
                        end
                        default: begin
                            state_d = S_DISCARD;
                        end
                    endcase
                end
                S_ADDR_H: begin
                    addr_hi_d = received_data[0];
                    state_d   = S_ADDR_L;
                end
                S_ADDR_L: begin
                    if (start_addr > LAST_ADDR) begin
                        addr_err_d = 1'b1;
                        state_d    = S_DISCARD;
                    end else begin
                        addr_d     = start_addr;
                        mem_addr_d = start_addr;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    addr_d = next_addr;
                    if (is_write_q) begin
                        mem_addr_d  = addr_q;
                        mem_wdata_d = received_data;
                        mem_we_d    = 1'b1;
`ifdef SPI_BURST_CHECKSUM_EN
                        csum_d      = csum_q ^ received_data;
`endif
                    end else begin
                        mem_addr_d = next_addr;
                    end
                end
                S_DISCARD: begin
                    state_d = S_DISCARD;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Testbench for spi_burst_sequencer: directed frames, write scoreboard
// drained by a monitor on mem_we, direct checks of flags and readback.

module tb_spi_burst_sequencer;

    logic       SCLK;
    logic       RESET;
    logic       SS;
    logic       data_valid;
    logic [7:0] received_data;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       clk_div_ready;
    logic       input_spike_ready;
    logic       debug_config_ready;
    logic       addr_error;
    logic [7:0] checksum;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

`ifdef SPI_BURST_CHECKSUM_EN
    localparam logic [7:0] CS_A = 8'hFF;
    localparam logic [7:0] CS_B = 8'h33;
`else
    localparam logic [7:0] CS_A = 8'h00;
    localparam logic [7:0] CS_B = 8'h00;
`endif

    spi_burst_sequencer #(
        .MEM_DEPTH(272),
        .ADDR_W(9)
    ) dut (
        .SCLK(SCLK),
        .RESET(RESET),
        .SS(SS),
        .data_valid(data_valid),
        .received_data(received_data),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .clk_div_ready(clk_div_ready),
        .input_spike_ready(input_spike_ready),
        .debug_config_ready(debug_config_ready),
        .addr_error(addr_error),
        .checksum(checksum)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Write monitor: every mem_we cycle must match the next expected write.
    always @(negedge SCLK) begin
        if (!RESET && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write got %0h=%0h want %0h=%0h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [8:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge SCLK);
        data_valid    = 1'b1;
        received_data = b;
        @(negedge SCLK);
        data_valid    = 1'b0;
    endtask

    task automatic ss_low;
        @(negedge SCLK);
        SS = 1'b0;
    endtask

    task automatic ss_high;
        @(negedge SCLK);
        SS = 1'b1;
        repeat (2) @(negedge SCLK);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp);
        chk(name, {clk_div_ready, input_spike_ready,
                   debug_config_ready, addr_error}, exp);
    endtask

    initial begin
        RESET         = 1'b0;
        SS            = 1'b1;
        data_valid    = 1'b0;
        received_data = 8'h00;
        #1 RESET = 1'b1;
        #2;
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_we", mem_we, 0);
        chk_flags("rst_flags", 4'b0000);
        chk("rst_csum", checksum, 0);
        repeat (2) @(negedge SCLK);
        RESET = 1'b0;

        // Two-byte write burst at 0x010.
        push(9'h010, 8'hAA);
        push(9'h011, 8'h55);
        ss_low;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'hAA);
        send_byte(8'h55);
        ss_high;
        chk("csum_burst", checksum, CS_A);
        chk("q_empty_burst", exp_q.size(), 0);

        // Wrap from 271 to 0.
        push(9'd271, 8'h11);
        push(9'd0, 8'h22);
        ss_low;
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h0F);
        send_byte(8'h11);
        send_byte(8'h22);
        ss_high;
        chk("csum_wrap", checksum, CS_B);
        chk("q_empty_wrap", exp_q.size(), 0);

        // Out-of-range start address: error flag, no writes.
        ss_low;
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h33);
        send_byte(8'h44);
        ss_high;
        chk_flags("addr_err_set", 4'b0001);

        ss_low;
        send_byte(8'h06);
        ss_high;
        chk_flags("addr_err_clr", 4'b0000);

        // Readback address sequence 5,6,7,8.
        ss_low;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h05);
        chk("rd_addr0", mem_addr, 5);
        send_byte(8'h00);
        chk("rd_addr1", mem_addr, 6);
        send_byte(8'h00);
        chk("rd_addr2", mem_addr, 7);
        send_byte(8'h00);
        chk("rd_addr3", mem_addr, 8);
        ss_high;

        // Flag opcodes.
        ss_low;
        send_byte(8'h04);
        send_byte(8'h03);
        ss_high;
        chk_flags("spike_only", 4'b0100);
        ss_low;
        send_byte(8'h05);
        ss_high;
        chk_flags("spike_dbg", 4'b0110);
        ss_low;
        send_byte(8'h06);
        ss_high;
        chk_flags("clear_all", 4'b0000);
        ss_low;
        send_byte(8'h7E);
        ss_high;
        chk_flags("nop", 4'b0000);

        // Abort after ADDR_L, then a SET_CLK_DIV frame.
        ss_low;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h20);
        ss_high;
        ss_low;
        send_byte(8'h03);
        ss_high;
        chk_flags("abort_clkdiv", 4'b1000);

        // Deselect coincident with a data byte: only the first byte lands.
        push(9'h030, 8'hAA);
        ss_low;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'hAA);
        @(negedge SCLK);
        SS            = 1'b1;
        data_valid    = 1'b1;
        received_data = 8'hBB;
        @(negedge SCLK);
        data_valid    = 1'b0;
        repeat (2) @(negedge SCLK);
        chk("q_empty_abort", exp_q.size(), 0);

        // Reset while a write strobe is high.
        ss_low;
        send_byte(8'h05);
        ss_high;
        ss_low;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h40);
        @(negedge SCLK);
        data_valid    = 1'b1;
        received_data = 8'h77;
        @(posedge SCLK);
        #1;
        RESET      = 1'b1;
        data_valid = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk_flags("midrst_flags", 4'b0000);
        chk("midrst_csum", checksum, 0);
        @(negedge SCLK);
        RESET = 1'b0;
        send_byte(8'h66);
        send_byte(8'h12);
        ss_high;

        push(9'h050, 8'h99);
        ss_low;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h99);
        ss_high;
        chk("q_empty_final", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst_sequencer.md
SPI_BURST_SEQUENCER -- requirements
Module: spi_burst_sequencer

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 272, meaning the number of configuration-memory bytes (valid addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the memory address width.
REQ-003 SHALL have port SCLK  input  1  SPI clock; the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port SS  input  1  chip select, active-low, sampled on SCLK rising edge.
REQ-006 SHALL have port data_valid  input  1  one-cycle pulse: a complete byte from the SPI byte slave is on received_data.
REQ-007 SHALL have port received_data  input  8  byte from the SPI byte slave.
REQ-008 SHALL have port mem_addr  output  ADDR_W  memory address for write and for readback (data_to_send).
REQ-009 SHALL have port mem_wdata  output  8  memory write data.
REQ-010 SHALL have port mem_we  output  1  memory write strobe, one SCLK cycle per byte.
REQ-011 SHALL have port clk_div_ready / input_spike_ready / debug_config_ready  output  1 each  sticky ready flags.
REQ-012 SHALL have port addr_error  output  1  sticky; a frame addressed a location >= MEM_DEPTH.
REQ-013 SHALL have port checksum  output  8  running XOR of the data bytes written in the current frame.

Function
REQ-014 SHALL decode the first byte of a frame as the opcode: 0x01 WRITE, 0x02 READ, 0x03 SET_CLK_DIV, 0x04 SET_SPIKE, 0x05 SET_DEBUG, 0x06 CLEAR_FLAGS; every other value SHALL be treated as NOP.
REQ-015 SHALL implement the states IDLE, ADDR_H, ADDR_L, DATA and DISCARD, advancing only on SCLK edges where data_valid=1.
REQ-016 SHALL, for WRITE/READ, move IDLE->ADDR_H; SHALL move every other opcode IDLE->DISCARD.
REQ-017 SHALL latch the ADDR_H byte bit[0] as address bit 8; SHALL latch the ADDR_L byte as address bits 7:0; SHALL then go ADDR_L->DATA.
REQ-018 SHALL, in WRITE DATA: on each data_valid, register mem_wdata=received_data, mem_addr=current address and mem_we=1 for exactly the next cycle (latency 1), then increment the address.
REQ-019 SHALL, in READ DATA: drive mem_addr with the start address on exit from ADDR_L; SHALL increment mem_addr on each data_valid; mem_we SHALL stay 0.
REQ-020 SHALL wrap the address from MEM_DEPTH-1 to 0 during a burst.
REQ-021 SHALL, when the start address is >= MEM_DEPTH, set addr_error, suppress all mem_we for the frame and go to DISCARD.
REQ-022 SHALL, for SET_* opcodes, set the matching flag on the opcode byte; CLEAR_FLAGS SHALL clear all three flags and addr_error.
REQ-023 SHALL, on any SCLK edge with SS=1, return to IDLE and drop mem_we, taking priority over a simultaneous data_valid.
REQ-024 SHALL ignore bytes in DISCARD until SS=1.
REQ-025 SHALL write no partial byte when a frame is aborted by SS; bytes already written SHALL remain in memory.

Reset
REQ-026 SHALL, on RESET=1, immediately set: state IDLE, mem_addr 0, mem_wdata 0, mem_we 0, all flags 0, addr_error 0, checksum 0.
REQ-027 SHALL, when RESET is asserted mid-burst, perform no further write after the reset edge; the next frame SHALL start from IDLE.

Configuration
REQ-028 SHALL, with SPI_BURST_CHECKSUM_EN defined, clear checksum on the IDLE->ADDR_H transition and XOR it with each written data byte in the same cycle mem_we is asserted.
REQ-029 SHALL, with SPI_BURST_CHECKSUM_EN undefined, tie checksum to 8'h00 and contain no checksum register.

Verification
REQ-030 SHALL cover: WRITE 0x01,0x00,0x10,0xAA,0x55 -> mem_we pulses at addr 0x010=0xAA and 0x011=0x55; checksum=0xFF (macro on).
REQ-031 SHALL cover: WRITE to 0x01,0x0F (271) with two data bytes -> writes to 271, then to 0 (wrap).
REQ-032 SHALL cover: WRITE to 0x01,0x20 (288) -> addr_error=1, no mem_we for the frame.
REQ-033 SHALL cover: READ 0x02,0x00,0x05 then three dummy bytes -> mem_addr sequence 5,6,7,8, mem_we never 1.
REQ-034 SHALL cover: opcode 0x04 -> input_spike_ready=1, others 0; then 0x06 -> all flags 0.
REQ-035 SHALL cover: SS=1 after the ADDR_L byte of a WRITE, then a new 0x03 frame -> no write, clk_div_ready=1; RESET mid-burst -> all outputs 0 asynchronously.
